// File: rtl/cmd_cfg_sched.sv
// Command scheduler: decodes one 24-bit UART frame at a time into flight setpoints,
// sequences calibration / battery reads, and returns one response byte per command.
// Optional comm-loss watchdog: define CMD_WDOG_EN.
module cmd_cfg_sched #(
   parameter int         RAMP_W  = 26,
   parameter logic [7:0] POS_ACK = 8'hA5,
   parameter logic [7:0] NEG_ACK = 8'hEE
`ifdef CMD_WDOG_EN
   ,
   parameter int         WDOG_W  = 26
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_rdy,
   input  logic [7:0]  cmd,
   input  logic [15:0] data,
   output logic        clr_cmd_rdy,
   output logic        send_resp,
   output logic [7:0]  resp,
   input  logic        resp_sent,
   input  logic [7:0]  batt,
   output logic        strt_cnv,
   input  logic        cnv_cmplt,
   output logic        inertial_cal,
   output logic        strt_cal,
   input  logic        cal_done,
   output logic        motors_off,
   output logic [15:0] d_ptch,
   output logic [15:0] d_roll,
   output logic [15:0] d_yaw,
   output logic [8:0]  thrst
);

   localparam logic [7:0] REQ_BATT  = 8'h01;
   localparam logic [7:0] SET_PTCH  = 8'h02;
   localparam logic [7:0] SET_ROLL  = 8'h03;
   localparam logic [7:0] SET_YAW   = 8'h04;
   localparam logic [7:0] SET_THRST = 8'h05;
   localparam logic [7:0] CALIBRATE = 8'h06;
   localparam logic [7:0] EMER_LAND = 8'h07;
   localparam logic [7:0] MTRS_OFF  = 8'h08;

   typedef enum logic [2:0] {IDLE, RAMP, CAL, BATT, RESP} state_t;

   state_t            state, nxt_state;
   logic [RAMP_W-1:0] ramp_cnt;
   logic              ramp_done;
   logic              resp_first;

   assign ramp_done = &ramp_cnt;

   // Pulses are combinational so a frame is consumed in the cycle it is seen.
   always_comb begin
      nxt_state   = state;
      clr_cmd_rdy = 1'b0;
      strt_cnv    = 1'b0;
      strt_cal    = 1'b0;
      send_resp   = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (cmd_rdy) begin
                  clr_cmd_rdy = 1'b1;
                  case (cmd)
                     CALIBRATE: nxt_state = RAMP;
                     REQ_BATT: begin
                        strt_cnv  = 1'b1;
                        nxt_state = BATT;
                     end
                     default:   nxt_state = RESP;
                  endcase
               end
            end
            RAMP: begin
               if (ramp_done) begin
                  strt_cal  = 1'b1;
                  nxt_state = CAL;
               end
            end
            CAL:  if (cal_done)  nxt_state = RESP;
            BATT: if (cnv_cmplt) nxt_state = RESP;
            RESP: begin
               send_resp = resp_first;
               if (resp_sent) nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
         endcase
      end
   end

`ifdef CMD_WDOG_EN
   logic [WDOG_W-1:0] wdog_cnt;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         ramp_cnt     <= '0;
         resp_first   <= 1'b0;
         resp         <= '0;
         d_ptch       <= '0;
         d_roll       <= '0;
         d_yaw        <= '0;
         thrst        <= '0;
         inertial_cal <= 1'b0;
         motors_off   <= 1'b1;
`ifdef CMD_WDOG_EN
         wdog_cnt     <= '0;
`endif
      end else begin
         state      <= nxt_state;
         resp_first <= (nxt_state == RESP) && (state != RESP);
         case (state)
            IDLE: begin
               if (cmd_rdy) begin
                  case (cmd)
                     SET_PTCH:  begin d_ptch <= data;      resp <= POS_ACK; end
                     SET_ROLL:  begin d_roll <= data;      resp <= POS_ACK; end
                     SET_YAW:   begin d_yaw  <= data;      resp <= POS_ACK; end
                     SET_THRST: begin thrst  <= data[8:0]; resp <= POS_ACK; end
                     EMER_LAND: begin
                        d_ptch <= '0;
                        d_roll <= '0;
                        d_yaw  <= '0;
                        thrst  <= '0;
                        resp   <= POS_ACK;
                     end
                     MTRS_OFF:  begin motors_off <= 1'b1; resp <= POS_ACK; end
                     CALIBRATE: begin
                        motors_off   <= 1'b0;
                        inertial_cal <= 1'b1;
                        ramp_cnt     <= '0;
                     end
                     REQ_BATT:  begin end
                     default:   resp <= NEG_ACK;
                  endcase
               end
            end
            // Counter parks at all-ones; the FSM leaves RAMP on that same cycle.
            RAMP: if (!ramp_done) ramp_cnt <= ramp_cnt + RAMP_W'(1);
            CAL: begin
               if (cal_done) begin
                  inertial_cal <= 1'b0;
                  resp         <= POS_ACK;
               end
            end
            BATT: if (cnv_cmplt) resp <= batt;
            default: begin end
         endcase
`ifdef CMD_WDOG_EN
         // A frame consumed on the saturated cycle wins over the watchdog clear.
         if (clr_cmd_rdy) begin
            wdog_cnt <= '0;
         end else begin
            if (!(&wdog_cnt)) wdog_cnt <= wdog_cnt + WDOG_W'(1);
            if (&wdog_cnt) begin
               d_ptch <= '0;
               d_roll <= '0;
               d_yaw  <= '0;
               thrst  <= '0;
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_cmd_cfg_sched.sv
// Bench for cmd_cfg_sched: directed scenarios plus randomized frames, checked every
// cycle against a transaction-level model of the scheduler.
module tb_cmd_cfg_sched;
   localparam int RAMP_W   = 9;
   localparam int RAMP_LEN = 1 << RAMP_W;
`ifdef CMD_WDOG_EN
   localparam int WDOG_W   = 8;
   localparam int WDOG_MAX = (1 << WDOG_W) - 1;
`endif
   localparam int P_FREE = 0, P_RAMP = 1, P_CAL = 2, P_BATT = 3, P_RESP = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_rdy = 1'b0;
   logic [7:0]  cmd = 8'h00;
   logic [15:0] data = 16'h0000;
   logic        clr_cmd_rdy, send_resp, strt_cnv, inertial_cal, strt_cal, motors_off;
   logic [7:0]  resp;
   logic        resp_sent;
   logic [7:0]  batt = 8'h00;
   logic        cnv_cmplt;
   logic        cal_done;
   logic [15:0] d_ptch, d_roll, d_yaw;
   logic [8:0]  thrst;

   always #5 clk = ~clk;

   cmd_cfg_sched #(
      .RAMP_W(RAMP_W), .POS_ACK(8'hA5), .NEG_ACK(8'hEE)
`ifdef CMD_WDOG_EN
      , .WDOG_W(WDOG_W)
`endif
   ) dut (
      .clk(clk), .rst(rst), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
      .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp),
      .resp_sent(resp_sent), .batt(batt), .strt_cnv(strt_cnv), .cnv_cmplt(cnv_cmplt),
      .inertial_cal(inertial_cal), .strt_cal(strt_cal), .cal_done(cal_done),
      .motors_off(motors_off), .d_ptch(d_ptch), .d_roll(d_roll), .d_yaw(d_yaw),
      .thrst(thrst)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit chk_en = 1'b0;
   bit spur = 1'b0;
   int cal_dly = 20;
   int cnv_dly = 40;

   // observed DUT events
   int last_clr = 0, last_cal = 0, n_cal = 0, n_rs = 0, clr_rs = 0, n_send = 0;
   logic [7:0] sent_q[$];

   // reference model
   int          ph = P_FREE;
   int          age = 0;
   int          wd = 0;
   logic [15:0] m_ptch = '0, m_roll = '0, m_yaw = '0;
   logic [8:0]  m_thrst = '0;
   logic        m_moff = 1'b1, m_ical = 1'b0;
   logic [7:0]  m_resp = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model advances on each clock edge from the inputs the DUT saw.
   initial begin : model
      bit consumed;
      forever begin
         @(posedge clk);
         consumed = !rst && ph == P_FREE && cmd_rdy;
         if (rst) begin
            ph = P_FREE; age = 0; wd = 0;
            m_ptch = '0; m_roll = '0; m_yaw = '0; m_thrst = '0;
            m_moff = 1'b1; m_ical = 1'b0; m_resp = '0;
         end else begin
            case (ph)
               P_FREE: if (cmd_rdy) begin
                  age = 0;
                  ph  = P_RESP;
                  case (cmd)
                     8'h01: ph = P_BATT;
                     8'h02: begin m_ptch = data; m_resp = 8'hA5; end
                     8'h03: begin m_roll = data; m_resp = 8'hA5; end
                     8'h04: begin m_yaw = data;  m_resp = 8'hA5; end
                     8'h05: begin m_thrst = data % 512; m_resp = 8'hA5; end
                     8'h06: begin m_moff = 1'b0; m_ical = 1'b1; ph = P_RAMP; end
                     8'h07: begin
                        m_ptch = '0; m_roll = '0; m_yaw = '0; m_thrst = '0; m_resp = 8'hA5;
                     end
                     8'h08: begin m_moff = 1'b1; m_resp = 8'hA5; end
                     default: m_resp = 8'hEE;
                  endcase
               end
               P_RAMP: if (age == RAMP_LEN - 1) ph = P_CAL; else age++;
               P_CAL: if (cal_done) begin
                  m_ical = 1'b0; m_resp = 8'hA5; ph = P_RESP; age = 0;
               end
               P_BATT: if (cnv_cmplt) begin
                  m_resp = batt; ph = P_RESP; age = 0;
               end
               default: begin
                  age++;
                  if (resp_sent) ph = P_FREE;
               end
            endcase
`ifdef CMD_WDOG_EN
            if (!consumed && wd == WDOG_MAX) begin
               m_ptch = '0; m_roll = '0; m_yaw = '0; m_thrst = '0;
            end
            if (consumed) wd = 0;
            else if (wd < WDOG_MAX) wd++;
`endif
         end
      end
   end

   // Compare process: every cycle once reset has been applied.
   initial begin : compare
      logic [13:0] e_out;
      forever begin
         @(negedge clk);
         cyc++;
         if (chk_en) begin
            e_out = {!rst && ph == P_FREE && cmd_rdy,
                     !rst && ph == P_RESP && age == 0,
                     !rst && ph == P_FREE && cmd_rdy && cmd == 8'h01,
                     !rst && ph == P_RAMP && age == RAMP_LEN - 1,
                     m_ical, m_moff, m_resp};
            check("outputs", {50'd0, clr_cmd_rdy, send_resp, strt_cnv, strt_cal,
                              inertial_cal, motors_off, resp}, {50'd0, e_out});
            check("setpoints", {7'd0, d_ptch, d_roll, d_yaw, thrst},
                  {7'd0, m_ptch, m_roll, m_yaw, m_thrst});
            if (resp_sent) n_rs++;
            if (clr_cmd_rdy) begin last_clr = cyc; clr_rs = n_rs; end
            if (strt_cal) begin last_cal = cyc; n_cal++; end
            if (send_resp) begin n_send++; sent_q.push_back(resp); end
         end
      end
   end

   initial begin : rs_resp
      int n = 0;
      resp_sent = 1'b0;
      forever begin
         @(negedge clk);
         if (send_resp) n = $urandom_range(1, 5);
         @(posedge clk); #1;
         resp_sent = 1'b0;
         if (n > 0) begin n--; if (n == 0) resp_sent = 1'b1; end
      end
   end

   initial begin : cal_resp
      int n = 0;
      cal_done = 1'b0;
      forever begin
         @(negedge clk);
         if (strt_cal) n = cal_dly;
         @(posedge clk); #1;
         cal_done = 1'b0;
         if (n > 0) begin n--; if (n == 0) cal_done = 1'b1; end
         else if (spur && $urandom_range(0, 15) == 0) cal_done = 1'b1;
      end
   end

   initial begin : cnv_resp
      int n = 0;
      cnv_cmplt = 1'b0;
      forever begin
         @(negedge clk);
         if (strt_cnv) n = cnv_dly;
         @(posedge clk); #1;
         cnv_cmplt = 1'b0;
         if (n > 0) begin n--; if (n == 0) cnv_cmplt = 1'b1; end
         else if (spur && $urandom_range(0, 15) == 0) cnv_cmplt = 1'b1;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [15:0] d);
      bit got = 1'b0;
      @(posedge clk); #1;
      cmd = c; data = d; cmd_rdy = 1'b1;
      for (int i = 0; i < 2000 && !got; i++) begin
         @(negedge clk);
         if (clr_cmd_rdy) got = 1'b1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL frame_consume: opcode %h not consumed within 2000 cycles", c);
      end
      @(posedge clk); #1;
      cmd_rdy = 1'b0;
   endtask

   task automatic wait_free();
      bit ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk);
         if (ph == P_FREE) ok = 1'b1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL wait_idle: command not completed within 3000 cycles");
      end
      tick(1);
   endtask

   task automatic cmd_done(input logic [7:0] c, input logic [15:0] d);
      send_frame(c, d);
      wait_free();
   endtask

   initial begin : global_limit
      #900000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin : main
      int c0, rs0, nc, ns0;
      logic [7:0] op;
      // 1: reset for two clocks
      rst = 1'b1;
      tick(1);
      chk_en = 1'b1;
      tick(1);
      rst = 1'b0;
      @(negedge clk);
      check("reset_motors_off", motors_off, 1);
      check("reset_setpoints", {d_ptch, d_roll, d_yaw, thrst}, 0);
      check("reset_send_resp", send_resp, 0);

      // 2: calibration
      ns0 = n_send;
      send_frame(8'h06, 16'h0000);
      c0 = last_clr;
      @(negedge clk);
      check("cal_motors_on", motors_off, 0);
      wait_free();
      check("cal_strt_delay", last_cal - c0, RAMP_LEN);
      check("cal_resp", sent_q[sent_q.size() - 1], 8'hA5);
      check("cal_one_send", n_send - ns0, 1);
      check("cal_ical_low", inertial_cal, 0);

      // 3: set commands
      cmd_done(8'h02, 16'h002A);
      cmd_done(8'h03, 16'h003A);
      cmd_done(8'h04, 16'hFF1F);
      cmd_done(8'h05, 16'h01FF);
      check("set_ptch", d_ptch, 16'h002A);
      check("set_roll", d_roll, 16'h003A);
      check("set_yaw", d_yaw, 16'hFF1F);
      check("set_thrst", thrst, 9'h1FF);
      for (int i = 1; i <= 4; i++)
         check("set_resp", sent_q[sent_q.size() - i], 8'hA5);

      // 4: battery read with a second frame waiting behind it
      batt = 8'hC3;
      rs0 = n_rs;
      send_frame(8'h01, 16'h0000);
      send_frame(8'h02, 16'h1234);
      wait_free();
      check("batt_resp", sent_q[sent_q.size() - 2], 8'hC3);
      check("busy_frame_after_resp", clr_rs, rs0 + 1);
      check("busy_frame_applied", d_ptch, 16'h1234);

      // 5: emergency land, motors off, undefined opcode
      cmd_done(8'h02, 16'h002A);
      cmd_done(8'h05, 16'h01FF);
      cmd_done(8'h07, 16'hFFFF);
      check("land_setpoints", {d_ptch, d_roll, d_yaw, thrst}, 0);
      check("land_resp", sent_q[sent_q.size() - 1], 8'hA5);
      cmd_done(8'h08, 16'h0000);
      check("mtrs_off", motors_off, 1);
      cmd_done(8'h02, 16'h0055);
      cmd_done(8'h3C, 16'h7777);
      check("undef_resp", sent_q[sent_q.size() - 1], 8'hEE);
      check("undef_keeps_ptch", d_ptch, 16'h0055);

      // 6: reset during ramp
      nc = n_cal;
      ns0 = n_send;
      send_frame(8'h06, 16'h0000);
      tick(100);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      @(negedge clk);
      check("rst_ical", inertial_cal, 0);
      check("rst_motors_off", motors_off, 1);
      tick(700);
      check("rst_no_strt_cal", n_cal, nc);
      check("rst_no_send", n_send, ns0);

      // comm-loss watchdog behaviour over a long idle gap
      cmd_done(8'h02, 16'h0077);
      tick(300);
`ifdef CMD_WDOG_EN
      check("wdog_ptch", d_ptch, 16'h0000);
`else
      check("no_wdog_ptch", d_ptch, 16'h0077);
`endif

      // 7: randomized frames, spurious done pulses, frames raised while busy
      spur = 1'b1;
      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 9))
            0: op = 8'h01;
            1: op = 8'h02;
            2: op = 8'h03;
            3: op = 8'h04;
            4: op = 8'h05;
            5: op = 8'h06;
            6: op = 8'h07;
            7: op = 8'h08;
            default: op = 8'($urandom);
         endcase
         batt = 8'($urandom);
         cal_dly = $urandom_range(1, 30);
         cnv_dly = $urandom_range(1, 30);
         send_frame(op, 16'($urandom));
         if ($urandom_range(0, 1) == 1) tick($urandom_range(0, 3));
      end
      wait_free();
      spur = 1'b0;
      tick(5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cmd_cfg_sched.md
Name: cmd_cfg_sched

Overview:
Command scheduler between the wireless UART wrapper and the flight datapath (flight controller, inertial interface, battery A2D interface). It performs the following steps:
- Accepts one 24-bit command frame at a time and decodes the opcode.
- Updates the desired pitch/roll/yaw/thrust registers.
- Sequences calibration (motor spin-up, then inertial calibration) and battery conversions.
- Returns exactly one response byte per command.

Parameters:
RAMP_W, 26, width of motor spin-up counter; calibration waits 2^RAMP_W clocks before starting inertial calibration (bench overrides to 9).
POS_ACK, 8'hA5, positive acknowledge byte.
NEG_ACK, 8'hEE, response to an undefined opcode.
WDOG_W, 26, width of the comm-loss watchdog counter (used only when CMD_WDOG_EN is defined).

Ports:
clk  in  1  system clock
rst  in  1  reset: synchronous, active-high, sampled on posedge clk
cmd_rdy  in  1  frame valid from the UART wrapper; held until clr_cmd_rdy
cmd  in  8  opcode
data  in  16  command data
clr_cmd_rdy  out  1  one-cycle pulse consuming the frame
send_resp  out  1  one-cycle pulse to transmit resp
resp  out  8  response byte, stable from send_resp until resp_sent
resp_sent  in  1  response byte transmitted
batt  in  8  latest battery reading from the A2D interface
strt_cnv  out  1  one-cycle pulse starting a battery conversion
cnv_cmplt  in  1  battery conversion finished
inertial_cal  out  1  high throughout the calibration sequence
strt_cal  out  1  one-cycle pulse starting inertial calibration
cal_done  in  1  inertial calibration finished
motors_off  out  1  forces ESCs to idle
d_ptch  out  16  desired pitch, signed
d_roll  out  16  desired roll, signed
d_yaw  out  16  desired yaw, signed
thrst  out  9  desired thrust, unsigned

Behaviour:
- Reset values:
  - State is IDLE.
  - d_ptch, d_roll, d_yaw, thrst, resp, clr_cmd_rdy, send_resp, strt_cnv, strt_cal and inertial_cal are all 0.
  - motors_off is 1.
- Opcodes:
  - 01 REQ_BATT
  - 02 SET_PTCH
  - 03 SET_ROLL
  - 04 SET_YAW
  - 05 SET_THRST
  - 06 CALIBRATE
  - 07 EMER_LAND
  - 08 MTRS_OFF
- States: IDLE, RAMP, CAL, BATT, RESP.
- IDLE, when cmd_rdy=1:
  - clr_cmd_rdy pulses in the same cycle; cmd and data are latched.
  - 02/03/04: the register is loaded with the full 16-bit data. resp=POS_ACK. Next state is RESP.
  - 05: thrst is loaded with data[8:0]; data[15:9] is ignored. resp=POS_ACK. Next state is RESP.
  - 07: d_ptch, d_roll, d_yaw and thrst are cleared. resp=POS_ACK. Next state is RESP.
  - 08: motors_off is set to 1. resp=POS_ACK. Next state is RESP.
  - 06: motors_off is cleared, inertial_cal is set, the ramp counter is cleared. Next state is RAMP.
  - 01: strt_cnv pulses. Next state is BATT.
  - Any other opcode: resp=NEG_ACK. Next state is RESP; no register changes.
- RAMP: the counter increments each clock. On the cycle the counter reaches all-ones, strt_cal pulses and the next state is CAL.
- CAL: waits for cal_done. Then inertial_cal clears, resp=POS_ACK, next state is RESP.
- BATT: waits for cnv_cmplt. Then resp=batt as sampled on that cycle, next state is RESP.
- RESP:
  - On the first cycle in RESP, send_resp pulses exactly once.
  - The block then waits for resp_sent, then returns to IDLE.
  - resp is held constant throughout RESP.
- Latency (cmd_rdy high in IDLE at cycle N):
  - Set/land/off commands: register updates visible at N+1, send_resp at N+1.
  - Calibrate: strt_cal at N+2^RAMP_W.
- Busy and simultaneous events:
  - cmd_rdy while not in IDLE is not consumed (no clr_cmd_rdy); the frame is taken on the first IDLE cycle.
  - cal_done or cnv_cmplt arriving outside their wait states is ignored.
  - A set command received while motors_off=1 updates the register; motors_off stays 1. Only CALIBRATE clears motors_off.
- Counters: the ramp counter never wraps; it stops at the exit condition.
- Reset mid-operation: rst in any state returns to IDLE with reset values next cycle.
  - inertial_cal drops and motors_off rises.
  - A pending response is discarded (no send_resp).

Optional Feature:
CMD_WDOG_EN:
- Defined: the watchdog counter clears whenever clr_cmd_rdy pulses and otherwise increments, saturating at all-ones. On reaching all-ones (2^WDOG_W−1 clocks with no consumed frame), d_ptch, d_roll, d_yaw and thrst are cleared, as for EMER_LAND, with no response sent. The clear is re-applied every cycle while the counter stays saturated.
- Not defined: no watchdog logic; the registers change only by command.

Test Plan:
1. Apply rst for 2 clocks -> motors_off=1; all desired registers 0; no send_resp.
2. With RAMP_W=9, send 06 -> motors_off=0 next cycle; strt_cal 512 clocks after consume; cal_done at +20 -> one send_resp with resp=8'hA5; inertial_cal low after cal_done.
3. Send 02/002A, then 03/003A, then 04/FF1F, then 05/01FF -> d_ptch=16'h002A, d_roll=16'h003A, d_yaw=16'hFF1F, thrst=9'h1FF; each command gets resp=A5.
4. Send 01 with batt=8'hC3, cnv_cmplt 40 clocks after strt_cnv -> resp=C3. A second frame raised during BATT is consumed only after resp_sent.
5. Preload the registers as in scenario 3, then send 07 -> all four registers 0 and resp=A5. Then send 08 -> motors_off=1. Then send 0x3C -> resp=EE and registers unchanged.
6. Assert rst during RAMP -> next cycle IDLE, inertial_cal=0, motors_off=1, no strt_cal. With CMD_WDOG_EN and WDOG_W=8, after 255 idle clocks the registers are 0.
